// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder: access sizes,
// responder states and the alignment/legality check.
package mem_pkg;

    typedef enum logic [1:0] {
        MT_BYTE = 2'b00,
        MT_HALF = 2'b01,
        MT_WORD = 2'b10,
        MT_RSVD = 2'b11
    } memtype_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } rsp_state_t;

    // Also flags the reserved size, so one check covers every illegal access.
    function automatic logic is_misaligned(input memtype_t memType, input logic [1:0] addrLo);
        case (memType)
            MT_BYTE: return 1'b0;
            MT_HALF: return addrLo[0];
            MT_WORD: return |addrLo;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load extender: picks 1, 2 or 4 bytes from the raw little-endian
// window and sign- or zero-extends them to the data width.
module mem_load_align
    import mem_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [31:0]   rawBytes,
    input  memtype_t      memType,
    input  logic          memSign,
    output logic [DW-1:0] extData
);

    always_comb begin
        extData = '0;
        case (memType)
            MT_BYTE: extData = memSign ? DW'($signed(rawBytes[7:0]))  : DW'(rawBytes[7:0]);
            MT_HALF: extData = memSign ? DW'($signed(rawBytes[15:0])) : DW'(rawBytes[15:0]);
            MT_WORD: extData = memSign ? DW'($signed(rawBytes))       : DW'(rawBytes);
            default: extData = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Target side of the CPU load/store port: one request at a time, a fixed number
// of wait cycles, then a held valid/ready response with extended read data.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 17,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_write_i,
    input  logic [DW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    input  logic [1:0]    req_memtype_i,
    input  logic          req_memsign_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o
);

    localparam int CW = 4;

    rsp_state_t    state, stateNext;
    logic [CW-1:0] waitCnt;

    logic          reqWrite;
    logic [AW-1:0] reqAddr;
    logic [DW-1:0] reqWdata;
    memtype_t      reqType;
    logic          reqSign;

    logic [7:0]    storage [0:(2**AW)-1];

    logic          accept;
    logic          enterResp;
    logic          curWrite;
    logic [AW-1:0] curAddr;
    logic [DW-1:0] curWdata;
    memtype_t      curType;
    logic          curSign;
    logic [AW-1:0] byteAddr [4];
    logic [31:0]   rawBytes;
    logic          accessErr;
    logic          storeEn;
    logic [DW-1:0] loadData;
    logic          unusedAddrHi;

    assign unusedAddrHi = ^req_addr_i[DW-1:AW];

    assign accept      = (state == IDLE) && req_valid_i;
    assign enterResp   = (accept && (LATENCY == 1)) || ((state == WAIT) && (waitCnt == CW'(1)));
    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == RESP);

    // With LATENCY==1 the access happens on the acceptance edge, before the
    // request registers are loaded, so the live inputs are used directly.
    assign curWrite = (state == IDLE) ? req_write_i               : reqWrite;
    assign curAddr  = (state == IDLE) ? req_addr_i[AW-1:0]        : reqAddr;
    assign curWdata = (state == IDLE) ? req_wdata_i               : reqWdata;
    assign curType  = (state == IDLE) ? memtype_t'(req_memtype_i) : reqType;
    assign curSign  = (state == IDLE) ? req_memsign_i             : reqSign;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            byteAddr[i] = curAddr + AW'(i);
        end
    end

    assign rawBytes  = {storage[byteAddr[3]], storage[byteAddr[2]],
                        storage[byteAddr[1]], storage[byteAddr[0]]};
    assign accessErr = is_misaligned(curType, curAddr[1:0]);
    assign storeEn   = enterResp && curWrite && !accessErr && rst;

    mem_load_align #(.DW(DW)) uLoadAlign (
        .rawBytes (rawBytes),
        .memType  (curType),
        .memSign  (curSign),
        .extData  (loadData)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (waitCnt == CW'(1)) stateNext = RESP;
            RESP:    if (rsp_ready_i) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                waitCnt <= CW'(LATENCY - 1);
            end else if (state == WAIT) begin
                waitCnt <= waitCnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            reqWrite <= req_write_i;
            reqAddr  <= req_addr_i[AW-1:0];
            reqWdata <= req_wdata_i;
            reqType  <= memtype_t'(req_memtype_i);
            reqSign  <= req_memsign_i;
        end
    end

    // Response registers are loaded on the single edge that enters RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else if (enterResp) begin
            rsp_err_o   <= accessErr;
            rsp_rdata_o <= (accessErr || curWrite) ? '0 : loadData;
        end else if ((state == RESP) && rsp_ready_i) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (storeEn) begin
            storage[byteAddr[0]] <= curWdata[7:0];
            if (curType != MT_BYTE) begin
                storage[byteAddr[1]] <= curWdata[15:8];
            end
            if (curType == MT_WORD) begin
                storage[byteAddr[2]] <= curWdata[23:16];
                storage[byteAddr[3]] <= curWdata[31:24];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench for data_mem_responder against a byte-array memory model.
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [1:0]  req_memtype_i = '0;
    logic        req_memsign_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [7:0] mdl [0:1023];

    data_mem_responder #(.DW(32), .AW(17), .LATENCY(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_write_i   (req_write_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .req_memtype_i (req_memtype_i),
        .req_memsign_i (req_memsign_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o)
    );

    always #5 clk = ~clk;

    // Reference: bytes of a little-endian array, value built arithmetically.
    function automatic void modelAccess(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                        input logic [1:0] mt, input logic s,
                                        output logic [31:0] expD, output logic expE);
        int base;
        int n;
        longint v;
        base = int'(a[9:0]);
        n = (mt == 2'd0) ? 1 : (mt == 2'd1) ? 2 : 4;
        expE = (mt == 2'd3) || ((base % n) != 0);
        expD = '0;
        if (!expE) begin
            if (w) begin
                for (int i = 0; i < n; i++) mdl[base + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v += longint'(mdl[base + i]) << (8 * i);
                if (s && v >= (64'sd1 << (8 * n - 1))) v -= (64'sd1 << (8 * n));
                expD = v[31:0];
            end
        end
    endfunction

    // Drives one transaction; lat counts edges from the accepting edge to valid (-1 on timeout).
    task automatic doAccess(input logic w, input logic [31:0] a, input logic [31:0] wd,
                            input logic [1:0] mt, input logic s,
                            output logic [31:0] rd, output logic er, output int lat);
        int guard;
        lat = -1;
        rd  = 'x;
        er  = 1'bx;
        @(negedge clk);
        guard = 0;
        while (!req_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid_i   = 1'b1;
        req_write_i   = w;
        req_addr_i    = a;
        req_wdata_i   = wd;
        req_memtype_i = mt;
        req_memsign_i = s;
        @(posedge clk);
        #1;
        req_valid_i   = 1'b0;
        req_write_i   = 1'($urandom);
        req_addr_i    = $urandom;
        req_wdata_i   = $urandom;
        req_memtype_i = 2'($urandom);
        req_memsign_i = 1'($urandom);
        guard = 1;
        while (!rsp_valid_o && guard <= 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (rsp_valid_o) begin
            lat = guard;
            rd  = rsp_rdata_o;
            er  = rsp_err_o;
            @(negedge clk);
            rsp_ready_i = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        nCompared++; if (req_ready_o !== 1'b1) begin nMismatched++; $display("FAIL reset_ready got %b want 1", req_ready_o); end
        nCompared++; if (rsp_valid_o !== 1'b0) begin nMismatched++; $display("FAIL reset_valid got %b want 0", rsp_valid_o); end
        nCompared++; if (rsp_rdata_o !== 32'h0) begin nMismatched++; $display("FAIL reset_rdata got %h want 0", rsp_rdata_o); end
        nCompared++; if (rsp_err_o !== 1'b0) begin nMismatched++; $display("FAIL reset_err got %b want 0", rsp_err_o); end
    endtask

    task automatic test_fill();
        logic [31:0] rd, expD, wd;
        logic        er, expE;
        int          lat;
        for (int k = 0; k < 256; k++) begin
            wd = $urandom;
            modelAccess(1'b1, 32'(4 * k), wd, 2'd2, 1'b0, expD, expE);
            doAccess(1'b1, 32'(4 * k), wd, 2'd2, 1'b0, rd, er, lat);
            nCompared++;
            if (er !== 1'b0 || rd !== 32'h0 || lat != LAT) begin
                nMismatched++;
                $display("FAIL fill_store @%h got err=%b rdata=%h lat=%0d want err=0 rdata=0 lat=%0d", 4 * k, er, rd, lat, LAT);
            end
        end
    endtask

    task automatic test_word();
        logic [31:0] rd, expD;
        logic        er, expE;
        int          lat;
        modelAccess(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, expD, expE);
        doAccess(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, rd, er, lat);
        nCompared++; if (lat != LAT) begin nMismatched++; $display("FAIL word_store_lat got %0d want %0d", lat, LAT); end
        nCompared++; if (er !== 1'b0 || rd !== 32'h0) begin nMismatched++; $display("FAIL word_store_rsp got err=%b rdata=%h want 0/0", er, rd); end
        doAccess(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, rd, er, lat);
        nCompared++; if (lat != LAT) begin nMismatched++; $display("FAIL word_load_lat got %0d want %0d", lat, LAT); end
        nCompared++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin nMismatched++; $display("FAIL word_load got %h err=%b want deadbeef err=0", rd, er); end
    endtask

    task automatic test_byte();
        logic [31:0] rd, expD;
        logic        er, expE;
        int          lat;
        modelAccess(1'b1, 32'h203, 32'hABCDEF80, 2'd0, 1'b0, expD, expE);
        doAccess(1'b1, 32'h203, 32'hABCDEF80, 2'd0, 1'b0, rd, er, lat);
        doAccess(1'b0, 32'h203, 32'h0, 2'd0, 1'b1, rd, er, lat);
        nCompared++; if (rd !== 32'hFFFFFF80) begin nMismatched++; $display("FAIL byte_signed got %h want ffffff80", rd); end
        doAccess(1'b0, 32'h203, 32'h0, 2'd0, 1'b0, rd, er, lat);
        nCompared++; if (rd !== 32'h00000080) begin nMismatched++; $display("FAIL byte_unsigned got %h want 00000080", rd); end
        modelAccess(1'b0, 32'h200, 32'h0, 2'd2, 1'b0, expD, expE);
        doAccess(1'b0, 32'h200, 32'h0, 2'd2, 1'b0, rd, er, lat);
        nCompared++; if (rd !== expD || rd[31:24] !== 8'h80) begin nMismatched++; $display("FAIL byte_word_view got %h want %h", rd, expD); end
    endtask

    task automatic test_half();
        logic [31:0] rd;
        logic        er;
        int          lat;
        doAccess(1'b0, 32'h102, 32'h0, 2'd1, 1'b1, rd, er, lat);
        nCompared++; if (rd !== 32'hFFFFDEAD || er !== 1'b0) begin nMismatched++; $display("FAIL half_signed got %h err=%b want ffffdead err=0", rd, er); end
        doAccess(1'b0, 32'h100, 32'h0, 2'd1, 1'b0, rd, er, lat);
        nCompared++; if (rd !== 32'h0000BEEF) begin nMismatched++; $display("FAIL half_unsigned got %h want 0000beef", rd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd;
        logic        er;
        int          lat;
        doAccess(1'b1, 32'h101, 32'h11112222, 2'd1, 1'b0, rd, er, lat);
        nCompared++; if (er !== 1'b1 || rd !== 32'h0) begin nMismatched++; $display("FAIL mis_half_store got err=%b rdata=%h want 1/0", er, rd); end
        doAccess(1'b1, 32'h102, 32'h33334444, 2'd2, 1'b0, rd, er, lat);
        nCompared++; if (er !== 1'b1 || rd !== 32'h0) begin nMismatched++; $display("FAIL mis_word_store got err=%b rdata=%h want 1/0", er, rd); end
        doAccess(1'b0, 32'h100, 32'h0, 2'd3, 1'b1, rd, er, lat);
        nCompared++; if (er !== 1'b1 || rd !== 32'h0) begin nMismatched++; $display("FAIL rsvd_load got err=%b rdata=%h want 1/0", er, rd); end
        doAccess(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, rd, er, lat);
        nCompared++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin nMismatched++; $display("FAIL mis_untouched got %h want deadbeef", rd); end
    endtask

    task automatic test_backpressure();
        int guard;
        @(negedge clk);
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h100; req_memtype_i = 2'd2; req_memsign_i = 1'b0;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        guard = 0;
        while (!rsp_valid_o && guard < 40) begin @(posedge clk); #1; guard++; end
        nCompared++; if (rsp_valid_o !== 1'b1) begin nMismatched++; $display("FAIL bp_valid_timeout got %b want 1", rsp_valid_o); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            nCompared++;
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hDEADBEEF || req_ready_o !== 1'b0) begin
                nMismatched++;
                $display("FAIL bp_hold c%0d got valid=%b rdata=%h ready=%b want 1/deadbeef/0", c, rsp_valid_o, rsp_rdata_o, req_ready_o);
            end
        end
        @(negedge clk);
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        nCompared++;
        if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0 || req_ready_o !== 1'b1) begin
            nMismatched++;
            $display("FAIL bp_release got valid=%b rdata=%h err=%b ready=%b want 0/0/0/1", rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, expD;
        logic        er, expE;
        int          lat;
        @(negedge clk);
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h300; req_wdata_i = 32'h12345678;
        req_memtype_i = 2'd2; req_memsign_i = 1'b0;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        nCompared++; if (req_ready_o !== 1'b0) begin nMismatched++; $display("FAIL rm_busy got ready=%b want 0", req_ready_o); end
        rst = 1'b0;
        #1;
        nCompared++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0) begin
            nMismatched++;
            $display("FAIL rm_async got ready=%b valid=%b rdata=%h err=%b want 1/0/0/0", req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        modelAccess(1'b0, 32'h300, 32'h0, 2'd2, 1'b0, expD, expE);
        doAccess(1'b0, 32'h300, 32'h0, 2'd2, 1'b0, rd, er, lat);
        nCompared++; if (rd !== expD || er !== 1'b0) begin nMismatched++; $display("FAIL rm_not_stored got %h want %h", rd, expD); end
    endtask

    task automatic test_random();
        logic [31:0] rd, expD, a, wd;
        logic        er, expE, w, s;
        logic [1:0]  mt;
        int          lat;
        for (int k = 0; k < 300; k++) begin
            w  = 1'($urandom_range(0, 2) == 0);
            mt = 2'($urandom_range(0, 3));
            s  = 1'($urandom);
            wd = $urandom;
            a  = {15'($urandom), 7'd0, 10'($urandom)};
            modelAccess(w, a, wd, mt, s, expD, expE);
            doAccess(w, a, wd, mt, s, rd, er, lat);
            nCompared++;
            if (rd !== expD || er !== expE || lat != LAT) begin
                nMismatched++;
                $display("FAIL rand%0d w=%b a=%h mt=%0d s=%b got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         k, w, a, mt, s, rd, er, lat, expD, expE, LAT);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        rst = 1'b1;
        test_reset();
        test_fill();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Handshaked data-memory responder: the target side of the CPU's load/store port.
- Accepts one request at a time (address, write data, memType, memSign) and performs the access after a parameterised number of wait cycles.
- Returns read data, sign/zero-extended per memType/memSign, through a valid/ready response channel.
- Lets the pipeline be brought up against a memory with wait states, replacing the zero-latency combinational RAM.

Parameters:
- DW, 32, data and address width.
- AW, 17, byte-address width of internal storage (2**AW bytes).
- LATENCY, 2, cycles from request acceptance to rsp_valid_o assertion; legal range 1..15.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  responder can accept a request.
- req_write_i  input  1  1 = store, 0 = load.
- req_addr_i  input  DW  byte address.
- req_wdata_i  input  DW  store data, right-aligned.
- req_memtype_i  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_memsign_i  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  consumer accepts response.
- rsp_rdata_o  output  DW  load result; 0 for stores and errors.
- rsp_err_o  output  1  misaligned or reserved-type access.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, wait counter = 0.
  - Storage contents are not cleared.
- Storage and addressing:
  - Byte-addressed, little-endian.
  - Only req_addr_i[AW-1:0] is used; upper bits are ignored, so addresses wrap.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o, capture write, addr, wdata, memtype and memsign into request registers.
  - Load the counter with LATENCY-1.
  - Go to RESP if LATENCY == 1, else go to WAIT.
- WAIT:
  - req_ready_o = 0; decrement the counter each cycle.
  - When the counter reaches 1 at a clock edge, go to RESP.
  - Acceptance to rsp_valid_o high is exactly LATENCY cycles.
- Entering RESP (single edge, shared by all paths):
  - Error check: err = (memtype == 11) | (half & addr[0]) | (word & |addr[1:0]).
  - If err: no storage write; rsp_rdata_o = 0; rsp_err_o = 1.
  - Store, no error: write 1, 2 or 4 low bytes of wdata at addr..addr+n-1; rsp_rdata_o = 0.
  - Load, no error: read bytes, extend to DW per memsign, register into rsp_rdata_o.
- RESP:
  - rsp_valid_o = 1; rsp_rdata_o and rsp_err_o are held stable while rsp_ready_i = 0.
  - On rsp_ready_i: go to IDLE, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0.
  - req_ready_o rises the following cycle; there is no same-cycle turnaround.
- Read-after-write: a load following a store to the same address returns the new data.
- Request inputs are ignored outside the IDLE acceptance cycle.
- Reset mid-operation:
  - Abort to IDLE and drop any pending response.
  - A store aborted before entering RESP is not performed.

Decomposition:
- Shared package mem_pkg:
  - enum memtype_t {MT_BYTE = 2'b00, MT_HALF = 2'b01, MT_WORD = 2'b10, MT_RSVD = 2'b11}.
  - enum rsp_state_t {IDLE, WAIT, RESP}.
  - function is_misaligned(memtype, addr[1:0]).
- Sub-module mem_load_align:
  - Combinational.
  - Inputs: 4 raw bytes starting at the access address, memtype, memsign.
  - Output: DW-bit extended result.
  - Instantiated once; exhaustively unit-testable.

Test Plan:
- Word store, then word load: store 0xDEADBEEF @0x100, then load word @0x100 -> rdata 0xDEADBEEF, err 0. With LATENCY=2, rsp_valid_o rises exactly 2 cycles after each acceptance.
- Byte store, signed and unsigned byte loads: store byte 0x80 @0x203, then signed byte load @0x203 -> 0xFFFFFF80. Unsigned byte load @0x203 -> 0x00000080. Word load @0x200 -> 0x80xxxxxx, other bytes unchanged.
- Half loads: signed half load @0x102 after the first scenario -> 0xFFFFDEAD.
- Misaligned store: half store @0x101 or word store @0x102 -> err 1, rdata 0. A later word load @0x100 still returns 0xDEADBEEF.
- Backpressure: hold rsp_ready_i = 0 for 5 cycles in RESP -> rsp_valid_o stays 1, rdata stable, req_ready_o stays 0. Release -> IDLE next cycle.
- Reset mid-operation: assert rst low during WAIT of a store of 0x12345678 @0x300 -> outputs go to reset values immediately. A later load @0x300 returns the prior contents, not 0x12345678.
